// File: rtl/axi_pkg.sv
// Shared AXI4 constants used by the instruction-side read bridge.
// Only the read-channel encodings the bridge needs are defined here.
package axi_pkg;

    localparam int          AXI_ID_WIDTH   = 4;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

    localparam logic [1:0]  SZ_BYTE        = 2'd0;
    localparam logic [1:0]  SZ_HALF        = 2'd1;
    localparam logic [1:0]  SZ_WORD        = 2'd2;

endpackage

// File: rtl/inst_axi_rd_bridge_counter.sv
// Outstanding-read counter: reserves an R slot at request acceptance and
// releases it when the matching read data returns.
module outstanding_counter #(
    parameter int CNT_WIDTH = 3,
    parameter int MAX       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Simultaneous inc and dec cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (dec_i && !inc_i) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign full_o  = (cnt_q >= MAX_C);
    assign empty_o = (cnt_q == '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(inc_i && !dec_i && full_o));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec_i && !inc_i && empty_o));

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// Converts i-cache SRAM-like single-word reads into AXI4 single-beat reads
// with one ID, so R data returns in issue order.
module inst_axi_rd_bridge
    import axi_pkg::*;
#(
    parameter int ID_WIDTH        = AXI_ID_WIDTH,
    parameter int INST_ID         = 0,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cache_inst_req,
    input  logic [1:0]          cache_inst_size,
    input  logic [31:0]         cache_inst_addr,
    output logic [31:0]         cache_inst_rdata,
    output logic                cache_inst_addr_ok,
    output logic                cache_inst_data_ok,
    output logic [ID_WIDTH-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_WIDTH-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic                bus_err
);

    logic                 arvalid_q;
    logic [31:0]          araddr_q;
    logic [2:0]           arsize_q;
    logic                 rready_q;
    logic                 bus_err_q;
    logic [CNT_WIDTH-1:0] cnt_w;
    logic                 full_w;
    logic                 empty_w;
    logic                 can_accept;
    logic                 addr_ok;
    logic                 data_ok;
    logic                 unused_rid;

    // A slot frees only at the clock edge after data_ok, so a full-stalled
    // request is accepted one cycle after the returning beat.
    assign can_accept = !arvalid_q && !full_w;
    assign addr_ok    = rst_n && cache_inst_req && can_accept;
    assign data_ok    = rst_n && rvalid && rlast && !empty_w;

    outstanding_counter #(
        .CNT_WIDTH (CNT_WIDTH),
        .MAX       (MAX_OUTSTANDING)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (addr_ok),
        .dec_i   (data_ok),
        .cnt_o   (cnt_w),
        .full_o  (full_w),
        .empty_o (empty_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arsize_q  <= '0;
            rready_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            rready_q  <= 1'b1;
            bus_err_q <= data_ok && (rresp != AXI_RESP_OKAY);
            if (addr_ok) begin
                arvalid_q <= 1'b1;
                araddr_q  <= cache_inst_addr;
                arsize_q  <= {1'b0, cache_inst_size};
            end else if (arvalid_q && arready) begin
                arvalid_q <= 1'b0;
            end
        end
    end

    assign cache_inst_addr_ok = addr_ok;
    assign cache_inst_data_ok = data_ok;
    assign cache_inst_rdata   = rdata;
    assign arid               = ID_WIDTH'(INST_ID);
    assign araddr             = araddr_q;
    assign arlen              = 8'd0;
    assign arsize             = arsize_q;
    assign arburst            = AXI_BURST_INCR;
    assign arvalid            = arvalid_q;
    assign rready             = rready_q;
    assign bus_err            = bus_err_q;
    assign unused_rid         = ^rid;

    // An R beat with nothing outstanding is dropped; flag it in simulation.
    a_no_orphan_r: assert property (@(posedge clk) disable iff (!rst_n)
        !(rvalid && empty_w));

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge: one task per scenario, inline checks
// against hand-computed values, and an expected-data queue for ordering.
module tb_inst_axi_rd_bridge;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] c_rdata;
    logic        addr_ok;
    logic        data_ok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        bus_err;

    int n_cmp;
    int n_fail;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    inst_axi_rd_bridge dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cache_inst_req     (req),
        .cache_inst_size    (size),
        .cache_inst_addr    (addr),
        .cache_inst_rdata   (c_rdata),
        .cache_inst_addr_ok (addr_ok),
        .cache_inst_data_ok (data_ok),
        .arid               (arid),
        .araddr             (araddr),
        .arlen              (arlen),
        .arsize             (arsize),
        .arburst            (arburst),
        .arvalid            (arvalid),
        .arready            (arready),
        .rid                (rid),
        .rdata              (rdata),
        .rresp              (rresp),
        .rlast              (rlast),
        .rvalid             (rvalid),
        .rready             (rready),
        .bus_err            (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b1; size = 2'd2; addr = 32'h1234_5678;
        arready = 1'b1; rid = '0; rdata = 32'h0; rresp = 2'b00;
        rlast = 1'b1; rvalid = 1'b1;
        #2;
        n_cmp++;
        if ({arvalid, araddr, arsize, rready, bus_err} !== {1'b0, 32'h0, 3'b000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_regs: got %b %h %b %b %b want 0 00000000 000 0 0",
                     arvalid, araddr, arsize, rready, bus_err);
        end
        n_cmp++;
        if ({addr_ok, data_ok} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_handshakes: got %b%b want 00", addr_ok, data_ok);
        end
        step();
        step();
        rst_n = 1'b1; req = 1'b0; rvalid = 1'b0;
        step();
        n_cmp++;
        if (rready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rready_after: got %b want 1", rready);
        end
    endtask

    task automatic test_single();
        step();
        req = 1'b1; addr = 32'hBFC0_0000; size = 2'd2; arready = 1'b1;
        #1;
        n_cmp++;
        if ({addr_ok, arid, arlen, arburst} !== {1'b1, 4'h0, 8'h00, 2'b01}) begin
            n_fail++;
            $display("FAIL single_accept: got %b %h %h %b want 1 0 00 01", addr_ok, arid, arlen, arburst);
        end
        step();
        req = 1'b0;
        #1;
        n_cmp++;
        if ({arvalid, araddr, arsize} !== {1'b1, 32'hBFC0_0000, 3'b010}) begin
            n_fail++;
            $display("FAIL single_ar: got %b %h %b want 1 bfc00000 010", arvalid, araddr, arsize);
        end
        step();
        n_cmp++;
        if ({arvalid, dut.cnt_w} !== {1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL single_ar_done: got %b %0d want 0 1", arvalid, dut.cnt_w);
        end
        step();
        rvalid = 1'b1; rdata = 32'h3C08_BFB0; rresp = 2'b00;
        #1;
        n_cmp++;
        if ({data_ok, c_rdata} !== {1'b1, 32'h3C08_BFB0}) begin
            n_fail++;
            $display("FAIL single_data: got %b %h want 1 3c08bfb0", data_ok, c_rdata);
        end
        step();
        rvalid = 1'b0;
        #1;
        n_cmp++;
        if ({data_ok, dut.cnt_w} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL single_cnt_zero: got %b %0d want 0 0", data_ok, dut.cnt_w);
        end
    endtask

    task automatic test_ar_stall();
        step();
        arready = 1'b0; req = 1'b1; addr = 32'h0000_0200; size = 2'd0;
        #1;
        n_cmp++;
        if (addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_accept: got %b want 1", addr_ok);
        end
        step();
        addr = 32'h0000_0204; size = 2'd2;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) step();
            #1;
            n_cmp++;
            if ({arvalid, araddr, arsize, addr_ok} !== {1'b1, 32'h0000_0200, 3'b000, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got %b %h %b %b want 1 00000200 000 0",
                         i, arvalid, araddr, arsize, addr_ok);
            end
        end
        step();
        arready = 1'b1;
        #1;
        n_cmp++;
        if ({arvalid, addr_ok} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_handshake: got %b%b want 10", arvalid, addr_ok);
        end
        step();
        n_cmp++;
        if ({arvalid, addr_ok} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_next_accept: got %b%b want 01", arvalid, addr_ok);
        end
        step();
        req = 1'b0;
        #1;
        n_cmp++;
        if ({arvalid, araddr, arsize} !== {1'b1, 32'h0000_0204, 3'b010}) begin
            n_fail++;
            $display("FAIL stall_second_ar: got %b %h %b want 1 00000204 010", arvalid, araddr, arsize);
        end
        step();
        rvalid = 1'b1; rdata = 32'h1111_1111;
        #1;
        n_cmp++;
        if ({data_ok, dut.cnt_w} !== {1'b1, 3'd2}) begin
            n_fail++;
            $display("FAIL stall_r1: got %b %0d want 1 2", data_ok, dut.cnt_w);
        end
        step();
        rdata = 32'h2222_2222;
        step();
        rvalid = 1'b0;
        #1;
        n_cmp++;
        if (dut.cnt_w !== 3'd0) begin
            n_fail++;
            $display("FAIL stall_drain: got %0d want 0", dut.cnt_w);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] resp_data[3];
        resp_data[0] = 32'hA000_0100;
        resp_data[1] = 32'hA000_0104;
        resp_data[2] = 32'hA000_0108;
        exp_q.push_back(32'hA000_0100);
        exp_q.push_back(32'hA000_0104);
        exp_q.push_back(32'hA000_0108);
        step();
        arready = 1'b1; req = 1'b1; addr = 32'h0000_0100; size = 2'd2;
        #1;
        n_cmp++;
        if (addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept0: got %b want 1", addr_ok);
        end
        step();
        addr = 32'h0000_0104;
        #1;
        n_cmp++;
        if (addr_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %b want 0", addr_ok);
        end
        step();
        n_cmp++;
        if (addr_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept1: got %b want 1", addr_ok);
        end
        step();
        addr = 32'h0000_0108;
        #1;
        step();
        n_cmp++;
        if ({dut.cnt_w, addr_ok, arvalid} !== {3'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_full: got %0d %b %b want 2 0 0", dut.cnt_w, addr_ok, arvalid);
        end
        step();
        rvalid = 1'b1; rdata = resp_data[0];
        #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if ({data_ok, c_rdata, addr_ok} !== {1'b1, exp_v, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_r0: got %b %h %b want 1 %h 0", data_ok, c_rdata, addr_ok, exp_v);
        end
        step();
        rvalid = 1'b0;
        #1;
        n_cmp++;
        if ({addr_ok, dut.cnt_w} !== {1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL b2b_accept2: got %b %0d want 1 1", addr_ok, dut.cnt_w);
        end
        step();
        req = 1'b0;
        #1;
        n_cmp++;
        if ({arvalid, araddr} !== {1'b1, 32'h0000_0108}) begin
            n_fail++;
            $display("FAIL b2b_ar2: got %b %h want 1 00000108", arvalid, araddr);
        end
        for (int i = 1; i < 3; i++) begin
            step();
            rvalid = 1'b1; rdata = resp_data[i];
            #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if ({data_ok, c_rdata} !== {1'b1, exp_v}) begin
                n_fail++;
                $display("FAIL b2b_r%0d: got %b %h want 1 %h", i, data_ok, c_rdata, exp_v);
            end
        end
        step();
        rvalid = 1'b0;
        #1;
        n_cmp++;
        if (dut.cnt_w !== 3'd0) begin
            n_fail++;
            $display("FAIL b2b_drain: got %0d want 0", dut.cnt_w);
        end
    endtask

    task automatic test_same_cycle();
        step();
        arready = 1'b1; req = 1'b1; addr = 32'h0000_0300; size = 2'd2;
        step();
        req = 1'b0;
        step();
        n_cmp++;
        if ({arvalid, dut.cnt_w} !== {1'b0, 3'd1}) begin
            n_fail++;
            $display("FAIL same_setup: got %b %0d want 0 1", arvalid, dut.cnt_w);
        end
        req = 1'b1; addr = 32'h0000_0304; rvalid = 1'b1; rdata = 32'h55AA_0300;
        #1;
        n_cmp++;
        if ({addr_ok, data_ok, c_rdata} !== {2'b11, 32'h55AA_0300}) begin
            n_fail++;
            $display("FAIL same_both: got %b%b %h want 11 55aa0300", addr_ok, data_ok, c_rdata);
        end
        step();
        req = 1'b0; rvalid = 1'b0;
        #1;
        n_cmp++;
        if ({dut.cnt_w, arvalid, araddr, data_ok} !== {3'd1, 1'b1, 32'h0000_0304, 1'b0}) begin
            n_fail++;
            $display("FAIL same_after: got %0d %b %h %b want 1 1 00000304 0",
                     dut.cnt_w, arvalid, araddr, data_ok);
        end
        step();
        rvalid = 1'b1; rdata = 32'h55AA_0304;
        #1;
        step();
        rvalid = 1'b0;
        #1;
        n_cmp++;
        if (dut.cnt_w !== 3'd0) begin
            n_fail++;
            $display("FAIL same_drain: got %0d want 0", dut.cnt_w);
        end
    endtask

    task automatic test_bus_err();
        step();
        arready = 1'b1; req = 1'b1; addr = 32'h0000_1000; size = 2'd2;
        step();
        req = 1'b0;
        step();
        rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++;
        if ({data_ok, c_rdata, bus_err} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL err_data: got %b %h %b want 1 deadbeef 0", data_ok, c_rdata, bus_err);
        end
        step();
        rvalid = 1'b0; rresp = 2'b00;
        #1;
        n_cmp++;
        if (bus_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_pulse: got %b want 1", bus_err);
        end
        step();
        n_cmp++;
        if ({bus_err, dut.cnt_w} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL err_clear: got %b %0d want 0 0", bus_err, dut.cnt_w);
        end
    endtask

    task automatic test_async_reset();
        step();
        arready = 1'b0; req = 1'b1; addr = 32'h0000_0400; size = 2'd2;
        step();
        req = 1'b0;
        #1;
        n_cmp++;
        if ({arvalid, dut.cnt_w} !== {1'b1, 3'd1}) begin
            n_fail++;
            $display("FAIL arst_setup: got %b %0d want 1 1", arvalid, dut.cnt_w);
        end
        #1;
        rst_n = 1'b0; req = 1'b1;
        #1;
        n_cmp++;
        if ({arvalid, dut.cnt_w, addr_ok, rready} !== {1'b0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL arst_immediate: got %b %0d %b %b want 0 0 0 0",
                     arvalid, dut.cnt_w, addr_ok, rready);
        end
        step();
        n_cmp++;
        if (addr_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_hold: got %b want 0", addr_ok);
        end
        rst_n = 1'b1; req = 1'b0; arready = 1'b1;
        step();
        req = 1'b1; addr = 32'h0000_0500; size = 2'd2;
        #1;
        n_cmp++;
        if ({rready, addr_ok} !== 2'b11) begin
            n_fail++;
            $display("FAIL arst_reaccept: got %b%b want 11", rready, addr_ok);
        end
        step();
        req = 1'b0;
        #1;
        n_cmp++;
        if ({arvalid, araddr} !== {1'b1, 32'h0000_0500}) begin
            n_fail++;
            $display("FAIL arst_ar: got %b %h want 1 00000500", arvalid, araddr);
        end
        step();
        step();
        rvalid = 1'b1; rdata = 32'h0BAD_F00D;
        #1;
        n_cmp++;
        if ({data_ok, c_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
            n_fail++;
            $display("FAIL arst_data: got %b %h want 1 0badf00d", data_ok, c_rdata);
        end
        step();
        rvalid = 1'b0;
        #1;
        n_cmp++;
        if (dut.cnt_w !== 3'd0) begin
            n_fail++;
            $display("FAIL arst_drain: got %0d want 0", dut.cnt_w);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_ar_stall();
        test_back_to_back();
        test_same_cycle();
        test_bus_err();
        test_async_reset();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
